dispatch_arbiter: RTL and testbench

DISPATCH_ARBITER -- requirements
Module: dispatch_arbiter

---
 rtl/dispatch_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dispatch_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_arbiter.sv
// dispatch_arbiter
//   Two-slot in-order dispatch into three reservation stations (simple ALU,
//   complex, FP) using per-station credit counters, with fence draining.
//
//   Optional feature macro: DISPATCH_DUAL_ISSUE_EN
//     defined   : slot B may dispatch alongside slot A
//     undefined : slot B is never accepted (ready_B, disp_v_B, disp_dst_B = 0)
//
//   Ports
//     clk, rst_n               clock, async active-low reset
//     valid_A/B, dctl_A/B      decode slots (B younger); dctl 11 simple|complex,
//     fence_A/B                01 complex, 10 FP, 00 none
//     rob_empty, flush         pipeline state
//     rel_simple/complex/fp    entries freed this cycle (0..2)
//     ready_A/B                combinational slot accept
//     disp_v_A/B, disp_dst_A/B registered dispatch strobe / target (01 S, 10 C, 11 FP)
//     stall                    registered, high while draining for a fence
module dispatch_arbiter #(
  parameter int SIMPLE_DEPTH  = 4,
  parameter int COMPLEX_DEPTH = 4,
  parameter int FP_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_A,
  input  logic       valid_B,
  input  logic [1:0] dctl_A,
  input  logic [1:0] dctl_B,
  input  logic       fence_A,
  input  logic       fence_B,
  input  logic       rob_empty,
  input  logic       flush,
  input  logic [1:0] rel_simple,
  input  logic [1:0] rel_complex,
  input  logic [1:0] rel_fp,
  output logic       ready_A,
  output logic       ready_B,
  output logic       disp_v_A,
  output logic       disp_v_B,
  output logic [1:0] disp_dst_A,
  output logic [1:0] disp_dst_B,
  output logic       stall
);

  localparam logic [3:0] LP_DS = 4'(SIMPLE_DEPTH);
  localparam logic [3:0] LP_DC = 4'(COMPLEX_DEPTH);
  localparam logic [3:0] LP_DF = 4'(FP_DEPTH);

  localparam logic [1:0] DST_S = 2'b01;
  localparam logic [1:0] DST_C = 2'b10;
  localparam logic [1:0] DST_F = 2'b11;

  typedef enum logic [1:0] {IDLE, DRAIN, FENCE_GO} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cred_s, r_cred_c, r_cred_f;
  logic       r_disp_v_A, r_disp_v_B, r_stall;
  logic [1:0] r_dst_A, r_dst_B;

  logic       w_ready_A, w_ready_B;
  logic [1:0] w_dst_A, w_dst_B;
  logic [2:0] w_rem_s, w_rem_c, w_rem_f;
  logic [1:0] w_gnt_s, w_gnt_c, w_gnt_f;

  // Station choice for one slot given the credits visible to it; 00 = none.
  function automatic logic [1:0] f_pick(input logic [1:0] dctl,
                                        input logic [2:0] s, c, f);
    logic [1:0] d;
    d = 2'b00;
    case (dctl)
      2'b11:   d = (s != 3'd0) ? DST_S : ((c != 3'd0) ? DST_C : 2'b00);
      2'b01:   d = (c != 3'd0) ? DST_C : 2'b00;
      2'b10:   d = (f != 3'd0) ? DST_F : 2'b00;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // Grants never exceed current credit, so the 4-bit sum cannot underflow;
  // only the upper bound needs clamping.
  function automatic logic [2:0] f_cred(input logic [2:0] cred,
                                        input logic [1:0] gnt, rel,
                                        input logic [3:0] depth);
    logic [3:0] t;
    t = {1'b0, cred} - {2'b00, gnt} + {2'b00, rel};
    return (t > depth) ? depth[2:0] : t[2:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ready_A   = 1'b0;
    w_ready_B   = 1'b0;
    w_dst_A     = 2'b00;
    w_dst_B     = 2'b00;
    w_rem_s     = r_cred_s;
    w_rem_c     = r_cred_c;
    w_rem_f     = r_cred_f;
    if (!flush) begin
      case (r_state)
        IDLE: begin
          if (valid_A) begin
            if (fence_A) begin
              w_state_nxt = DRAIN;
            end else begin
              w_dst_A   = f_pick(dctl_A, r_cred_s, r_cred_c, r_cred_f);
              w_ready_A = (dctl_A == 2'b00) || (w_dst_A != 2'b00);
            end
          end
        end
        DRAIN: begin
          if (rob_empty && !r_disp_v_A && !r_disp_v_B) w_state_nxt = FENCE_GO;
        end
        FENCE_GO: begin
          // Fence retires from slot A without occupying a station.
          w_ready_A   = valid_A;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
`ifdef DISPATCH_DUAL_ISSUE_EN
      // B sees the credits A left behind, so a shared target needs two.
      if (r_state == IDLE && w_ready_A && valid_B && !fence_B) begin
        w_rem_s   = r_cred_s - 3'(w_dst_A == DST_S);
        w_rem_c   = r_cred_c - 3'(w_dst_A == DST_C);
        w_rem_f   = r_cred_f - 3'(w_dst_A == DST_F);
        w_dst_B   = f_pick(dctl_B, w_rem_s, w_rem_c, w_rem_f);
        w_ready_B = (dctl_B == 2'b00) || (w_dst_B != 2'b00);
      end
`endif
    end
  end

`ifndef DISPATCH_DUAL_ISSUE_EN
  logic w_unused;
  assign w_unused = ^{valid_B, dctl_B, fence_B, w_rem_s, w_rem_c, w_rem_f};
`endif

  assign w_gnt_s = 2'(w_ready_A && w_dst_A == DST_S) + 2'(w_ready_B && w_dst_B == DST_S);
  assign w_gnt_c = 2'(w_ready_A && w_dst_A == DST_C) + 2'(w_ready_B && w_dst_B == DST_C);
  assign w_gnt_f = 2'(w_ready_A && w_dst_A == DST_F) + 2'(w_ready_B && w_dst_B == DST_F);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cred_s   <= LP_DS[2:0];
      r_cred_c   <= LP_DC[2:0];
      r_cred_f   <= LP_DF[2:0];
      r_disp_v_A <= 1'b0;
      r_disp_v_B <= 1'b0;
      r_dst_A    <= 2'b00;
      r_dst_B    <= 2'b00;
      r_stall    <= 1'b0;
    end else if (flush) begin
      r_state    <= IDLE;
      r_cred_s   <= LP_DS[2:0];
      r_cred_c   <= LP_DC[2:0];
      r_cred_f   <= LP_DF[2:0];
      r_disp_v_A <= 1'b0;
      r_disp_v_B <= 1'b0;
      r_dst_A    <= 2'b00;
      r_dst_B    <= 2'b00;
      r_stall    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cred_s   <= f_cred(r_cred_s, w_gnt_s, rel_simple,  LP_DS);
      r_cred_c   <= f_cred(r_cred_c, w_gnt_c, rel_complex, LP_DC);
      r_cred_f   <= f_cred(r_cred_f, w_gnt_f, rel_fp,      LP_DF);
      r_disp_v_A <= w_ready_A && (w_dst_A != 2'b00);
      r_disp_v_B <= w_ready_B && (w_dst_B != 2'b00);
      r_dst_A    <= w_ready_A ? w_dst_A : 2'b00;
      r_dst_B    <= w_ready_B ? w_dst_B : 2'b00;
      r_stall    <= (w_state_nxt == DRAIN);
    end
  end

  assign ready_A    = w_ready_A;
  assign ready_B    = w_ready_B;
  assign disp_v_A   = r_disp_v_A;
  assign disp_v_B   = r_disp_v_B;
  assign disp_dst_A = r_dst_A;
  assign disp_dst_B = r_dst_B;
  assign stall      = r_stall;

endmodule

// File: tb/tb_dispatch_arbiter.sv
module tb_dispatch_arbiter;
`ifdef DISPATCH_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid_A, valid_B, fence_A, fence_B, rob_empty, flush;
  logic [1:0] dctl_A, dctl_B, rel_simple, rel_complex, rel_fp;
  logic ready_A, ready_B, disp_v_A, disp_v_B, stall;
  logic [1:0] disp_dst_A, disp_dst_B;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dispatch_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .valid_A(valid_A), .valid_B(valid_B), .dctl_A(dctl_A), .dctl_B(dctl_B),
    .fence_A(fence_A), .fence_B(fence_B), .rob_empty(rob_empty), .flush(flush),
    .rel_simple(rel_simple), .rel_complex(rel_complex), .rel_fp(rel_fp),
    .ready_A(ready_A), .ready_B(ready_B), .disp_v_A(disp_v_A), .disp_v_B(disp_v_B),
    .disp_dst_A(disp_dst_A), .disp_dst_B(disp_dst_B), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    valid_A = 0; valid_B = 0; dctl_A = 0; dctl_B = 0; fence_A = 0; fence_B = 0;
    rob_empty = 0; flush = 0; rel_simple = 0; rel_complex = 0; rel_fp = 0;
  endtask

  // inputs change 1 after the edge; combinational checks happen 1 later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setA(input logic [1:0] d);
    idle(); valid_A = 1; dctl_A = d;
  endtask

  task automatic creds(input string tag, input int s, input int c, input int f);
    chk({tag, "_cs"}, 32'(dut.r_cred_s), 32'(s));
    chk({tag, "_cc"}, 32'(dut.r_cred_c), 32'(c));
    chk({tag, "_cf"}, 32'(dut.r_cred_f), 32'(f));
  endtask

  task automatic do_flush();
    idle(); flush = 1; tick(); idle();
  endtask

  initial begin
    idle();
    #12;
    chk("rst_dv_A", 32'(disp_v_A), 0);
    chk("rst_dv_B", 32'(disp_v_B), 0);
    chk("rst_dst_A", 32'(disp_dst_A), 0);
    chk("rst_stall", 32'(stall), 0);
    creds("rst", 4, 4, 4);
    #5 rst_n = 1;
    tick();

    // both slots simple-or-complex
    idle(); valid_A = 1; dctl_A = 2'b11; valid_B = 1; dctl_B = 2'b11; #1;
    chk("t1_rdyA", 32'(ready_A), 1);
    chk("t1_rdyB", 32'(ready_B), 32'(DUAL));
    tick();
    chk("t1_dvA", 32'(disp_v_A), 1);
    chk("t1_dstA", 32'(disp_dst_A), 1);
    chk("t1_dvB", 32'(disp_v_B), 32'(DUAL));
    chk("t1_dstB", 32'(disp_dst_B), DUAL ? 1 : 0);
    chk("t1_cs", 32'(dut.r_cred_s), DUAL ? 2 : 3);
    idle(); tick();
    chk("t1_dvA_off", 32'(disp_v_A), 0);
    chk("t1_dstA_off", 32'(disp_dst_A), 0);
    do_flush();
    creds("t1_fl", 4, 4, 4);

    // exhaust simple (4) and complex down to 1
    for (int i = 0; i < 4; i++) begin setA(2'b11); tick(); end
    for (int i = 0; i < 3; i++) begin setA(2'b01); tick(); end
    creds("t2_pre", 0, 1, 4);
    idle(); valid_A = 1; dctl_A = 2'b11; valid_B = 1; dctl_B = 2'b01; #1;
    chk("t2_rdyA", 32'(ready_A), 1);
    chk("t2_rdyB", 32'(ready_B), 0);
    tick();
    chk("t2_dstA", 32'(disp_dst_A), 2);
    chk("t2_dvB", 32'(disp_v_B), 0);
    creds("t2", 0, 0, 4);

    // release is not usable in its own cycle
    setA(2'b01); rel_complex = 2; #1;
    chk("t3_rej", 32'(ready_A), 0);
    tick();
    chk("t3_dv0", 32'(disp_v_A), 0);
    chk("t3_cc2", 32'(dut.r_cred_c), 2);
    setA(2'b01); #1;
    chk("t3_acc", 32'(ready_A), 1);
    tick();
    chk("t3_dst", 32'(disp_dst_A), 2);
    chk("t3_cc1", 32'(dut.r_cred_c), 1);

    // dctl 00 accepted with no strobe and no credit
    setA(2'b00); #1;
    chk("t4_rdy", 32'(ready_A), 1);
    tick();
    chk("t4_dv", 32'(disp_v_A), 0);
    creds("t4", 0, 1, 4);

    // invalid slot never ready
    idle(); dctl_A = 2'b01; #1;
    chk("t5_inv", 32'(ready_A), 0);

    // fence on B only blocks B
    setA(2'b01); valid_B = 1; dctl_B = 2'b10; fence_B = 1; #1;
    chk("t6_rdyA", 32'(ready_A), 1);
    chk("t6_rdyB", 32'(ready_B), 0);
    tick();
    chk("t6_dstA", 32'(disp_dst_A), 2);
    chk("t6_dvB", 32'(disp_v_B), 0);

    // release clamp at depth, and release into empty station
    idle(); rel_fp = 2; rel_simple = 2; tick();
    creds("t7", 2, 0, 4);

    // flush in IDLE blocks acceptance and restores credits
    setA(2'b11); flush = 1; #1;
    chk("t8_rdy", 32'(ready_A), 0);
    tick();
    chk("t8_dv", 32'(disp_v_A), 0);
    creds("t8", 4, 4, 4);

    if (DUAL) begin
      // B needs a second credit when sharing A's station
      for (int i = 0; i < 3; i++) begin setA(2'b11); tick(); end
      idle(); valid_A = 1; dctl_A = 2'b11; valid_B = 1; dctl_B = 2'b11; #1;
      chk("t9_rdyB", 32'(ready_B), 1);
      tick();
      chk("t9_dstA", 32'(disp_dst_A), 1);
      chk("t9_dstB", 32'(disp_dst_B), 2);
      creds("t9", 0, 3, 4);
      do_flush();
    end

    // fence drain
    idle(); valid_A = 1; fence_A = 1; valid_B = 1; dctl_B = 2'b11; #1;
    chk("f_rdy0", 32'(ready_A), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f_stall", 32'(stall), 1);
      chk("f_rdyD", 32'(ready_A), 0);
    end
    rob_empty = 1;
    tick();
    chk("f_go_stall", 32'(stall), 0);
    chk("f_go_rdyA", 32'(ready_A), 1);
    chk("f_go_rdyB", 32'(ready_B), 0);
    tick();
    idle();
    chk("f_dvA", 32'(disp_v_A), 0);
    chk("f_dvB", 32'(disp_v_B), 0);
    creds("f", 4, 4, 4);
    setA(2'b11); #1;
    chk("f_idle_rdy", 32'(ready_A), 1);
    tick();

    // flush during DRAIN with simple credit 1
    for (int i = 0; i < 2; i++) begin setA(2'b11); tick(); end
    chk("g_cs1", 32'(dut.r_cred_s), 1);
    idle(); valid_A = 1; fence_A = 1; tick();
    chk("g_stall", 32'(stall), 1);
    flush = 1; rel_simple = 2; #1;
    chk("g_rdy", 32'(ready_A), 0);
    tick();
    chk("g_stall0", 32'(stall), 0);
    chk("g_dv", 32'(disp_v_A), 0);
    creds("g", 4, 4, 4);
    setA(2'b11); #1;
    chk("g_idle", 32'(ready_A), 1);
    tick();
    chk("g_dst", 32'(disp_dst_A), 1);

    // reset while draining abandons the fence; it restarts from IDLE
    idle(); valid_A = 1; fence_A = 1; rob_empty = 1; tick();
    chk("r_stall1", 32'(stall), 1);
    #1 rst_n = 0; #1;
    chk("r_stall0", 32'(stall), 0);
    creds("r", 4, 4, 4);
    #1 rst_n = 1;
    tick();
    chk("r_redrain", 32'(stall), 1);
    tick();
    chk("r_go", 32'(ready_A), 1);
    idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
